// File: rtl/utm_tape_controller_pkg.sv
// utm_tape_controller_pkg
// Shared definitions for the UTM tape controller slice:
//   - state_t           : controller FSM encoding
//   - DIR_LEFT/RIGHT    : meaning of the core's direction bit
//   - DEFAULT_HALT_STATE: encoded core state that ends a run
//   - SYM_W / STEP_W    : tape symbol width and step counter width
package utm_tape_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic       DIR_LEFT           = 1'b0;
  localparam logic       DIR_RIGHT          = 1'b1;
  localparam logic [2:0] DEFAULT_HALT_STATE = 3'd7;
  localparam int         SYM_W              = 3;
  localparam int         STEP_W             = 16;

  // Host access (load, start) is only allowed while the machine is stopped.
  function automatic logic is_stopped(state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/utm_tape_controller_mem.sv
// utm_tape_mem
// TAPE_LEN x 3-bit tape register array.
// Ports:
//   clock, reset_n       : clock, async active-low clear of every cell
//   wr_en/wr_addr/wr_sym : single write port (host or EXEC, muxed by the top)
//   head_addr/head_sym   : combinational read port for the symbol under the head
//   rd_addr/rd_sym       : combinational host read port
module utm_tape_mem
  import utm_tape_controller_pkg::*;
#(
  parameter int TAPE_LEN = 16,
  parameter int AW       = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SYM_W-1:0] wr_sym,
  input  logic [AW-1:0]    head_addr,
  output logic [SYM_W-1:0] head_sym,
  input  logic [AW-1:0]    rd_addr,
  output logic [SYM_W-1:0] rd_sym
);

  logic [SYM_W-1:0] cells [TAPE_LEN];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPE_LEN; i++) cells[i] <= '0;
    end else if (wr_en) begin
      cells[wr_addr] <= wr_sym;
    end
  end

  assign head_sym = cells[head_addr];
  assign rd_sym   = cells[rd_addr];

endmodule

// File: rtl/utm_tape_controller.sv
// utm_tape_controller
// Tape-side partner of the UTM core. Holds the tape, tracks the head, feeds the
// symbol under the head to the core (FETCH), applies the core's write/move
// result (EXEC) and stops on halt state, step limit or a move off the tape.
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   start, head_init, max_steps    : run control (accepted in IDLE/DONE)
//   load_en/load_addr/load_sym     : host tape write (IDLE/DONE only)
//   rd_addr -> rd_sym              : combinational host tape read
//   core_reset, sym_out, sym_valid : drive the core (reset, symbol handshake)
//   new_sym, direction,
//   encoded_next_state             : core results for the current step
//   head, step_count               : head position, completed steps
//   busy, halted, timeout, fault   : run status
module utm_tape_controller
  import utm_tape_controller_pkg::*;
#(
  parameter int         TAPE_LEN   = 16,
  parameter int         AW         = 4,
  parameter logic [2:0] HALT_STATE = DEFAULT_HALT_STATE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AW-1:0]     head_init,
  input  logic [STEP_W-1:0] max_steps,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [SYM_W-1:0]  load_sym,
  input  logic [AW-1:0]     rd_addr,
  output logic [SYM_W-1:0]  rd_sym,
  output logic              core_reset,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_valid,
  input  logic [SYM_W-1:0]  new_sym,
  input  logic              direction,
  input  logic [2:0]        encoded_next_state,
  output logic [AW-1:0]     head,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              halted,
  output logic              timeout,
  output logic              fault
);

  state_t            state_q, state_d;
  logic [AW-1:0]     head_q;
  logic [STEP_W-1:0] step_q;
  logic              halted_q, timeout_q, fault_q;

  logic              stopped;
  logic              accept_start;
  logic              edge_fault;
  logic              halt_hit;
  logic              limit_hit;
  logic [STEP_W-1:0] step_inc;
  logic [AW-1:0]     head_moved;

  logic              host_wr, exec_wr;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [SYM_W-1:0]  mem_wr_sym;
  logic [SYM_W-1:0]  head_sym;

  assign stopped      = is_stopped(state_q);
  assign accept_start = stopped && start;
  assign step_inc     = step_q + 16'd1;

  // A move is illegal when it would step past either end of the tape.
  assign edge_fault = (direction == DIR_RIGHT) ? (head_q == AW'(TAPE_LEN - 1))
                                               : (head_q == '0);
  assign head_moved = (direction == DIR_RIGHT) ? head_q + AW'(1) : head_q - AW'(1);
  assign halt_hit   = (encoded_next_state == HALT_STATE);
  assign limit_hit  = (max_steps != '0) && (step_inc == max_steps);

  // ---- tape memory: one write port shared by host (stopped) and EXEC ----
  assign host_wr     = stopped && load_en;
  assign exec_wr     = (state_q == ST_EXEC);
  assign mem_wr_en   = host_wr || exec_wr;
  assign mem_wr_addr = exec_wr ? head_q  : load_addr;
  assign mem_wr_sym  = exec_wr ? new_sym : load_sym;

  utm_tape_mem #(
    .TAPE_LEN (TAPE_LEN),
    .AW       (AW)
  ) u_mem (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (mem_wr_en),
    .wr_addr   (mem_wr_addr),
    .wr_sym    (mem_wr_sym),
    .head_addr (head_q),
    .head_sym  (head_sym),
    .rd_addr   (rd_addr),
    .rd_sym    (rd_sym)
  );

  // ---- FSM state register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_EXEC;
      ST_EXEC:          state_d = (edge_fault || halt_hit || limit_hit) ? ST_DONE : ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  // The core is held in reset whenever the controller is stopped, so each run
  // starts from core state 0 with an empty symbol buffer.
  always_comb begin
    sym_valid  = 1'b0;
    busy       = 1'b0;
    core_reset = 1'b1;
    unique case (state_q)
      ST_FETCH: begin
        sym_valid  = 1'b1;
        busy       = 1'b1;
        core_reset = 1'b0;
      end
      ST_EXEC: begin
        busy       = 1'b1;
        core_reset = 1'b0;
      end
      default: ;
    endcase
  end

  // ---- head, step counter and status flags ----
  // Fault has priority over halt, halt over step limit; the tape write still
  // lands on a faulting step, only the head move is suppressed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= '0;
      step_q    <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (accept_start) begin
      head_q    <= head_init;
      step_q    <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      step_q <= step_inc;
      if (edge_fault) begin
        fault_q <= 1'b1;
      end else begin
        head_q <= head_moved;
        if (halt_hit)       halted_q  <= 1'b1;
        else if (limit_hit) timeout_q <= 1'b1;
      end
    end
  end

  assign sym_out    = head_sym;
  assign head       = head_q;
  assign step_count = step_q;
  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign fault      = fault_q;

endmodule
